wave_voice_sequencer: RTL and testbench
=======================================

Name: wave_voice_sequencer

Overview:
Sample-rate scheduler and switch controller for the four waveform generators (sine, square, triangle, sawtooth). It divides the system clock down to a sample tick and pulses the selected generator's ready on each tick. It ramps an envelope down and up around every waveform change or mute so switches are click-free, applies a gain, and presents one sample per tick on a valid/ready stream to the audio sink (WAV writer or codec serializer).

Parameters:
width_p, 24, sample width in bits (signed two's complement)
clks_per_sample_p, 385, clock cycles per sample tick (17 MHz / 44.1 kHz); must be >= 4
ramp_len_p, 64, envelope steps per ramp; must be a power of 2, >= 2

Ports:
clk_i  input  1  system clock
reset_i  input  1  asynchronous reset, active-high
sel_i  input  4  requested voice, one-hot: [0] sine, [1] square, [2] triangle, [3] saw; 0000 = mute
sel_valid_i  input  1  selection request valid
sel_ready_o  output  1  selection request accepted when sel_valid_i & sel_ready_o
gain_i  input  9  unsigned gain; 256 = unity; values > 256 clamp to 256; sampled at each tick
gen_ready_o  output  4  one-hot per generator; pulses for one cycle on a tick for the current voice
gen_valid_i  input  4  generator valid, same bit order
gen_data_i  input  4*width_p  packed generator samples; slice k = generator k
data_o  output  width_p  output sample, signed
valid_o  output  1  data_o valid
ready_i  input  1  sink ready
overrun_o  output  1  sticky: an unconsumed sample was overwritten
underrun_o  output  1  sticky: current generator was not valid at a tick

Behaviour:
- Reset (asynchronous, immediate, any state): state IDLE, cur = 0000, pend = 0000, env = 0, tick counter = 0. All outputs are 0, except sel_ready_o, which is 1 (IDLE).
- Tick: the counter runs 0..clks_per_sample_p-1 and wraps. tick = 1 when the counter equals clks_per_sample_p-1, so the first tick falls on the clks_per_sample_p-th rising edge after reset deasserts.
- gen_ready_o = cur & {4{tick}}.
- Source capture on a tick: if cur != 0 and gen_valid_i[cur] = 1, src = gen_data_i slice. Otherwise src = 0. If cur != 0 and gen_valid_i[cur] = 0, underrun_o is set.
- Sample arithmetic uses the env value before this tick's step:
  - s1 = (src * env) >>> log2(ramp_len_p)
  - s2 = (s1 * min(gain_i, 256)) >>> 8
  - Both shifts are arithmetic (floor toward -inf).
  - Intermediate widths are wide enough that no overflow occurs; the result fits width_p.
- Pipeline: two stages. The tick at cycle t gives data_o and valid_o at t+2. A sample is produced on every tick, including in IDLE, where it is 0.
- Output handshake:
  - valid_o holds until ready_i = 1.
  - If a new result arrives while valid_o = 1 and ready_i = 0, data_o is overwritten and overrun_o is set.
  - A new result arriving in the same cycle as a handshake loads with valid_o = 1.
- Selection: any code whose popcount is not 1 is treated as 0000 (mute). A request accepted at cycle t first affects the tick at t+1 or later.
- FSM (env steps only on ticks):
  - IDLE: sel_ready_o = 1. Accepting a nonzero code sets cur = code, env = 0, goes to RAMP_UP. Accepting mute is a no-op.
  - RAMP_UP: sel_ready_o = 0. Each tick env += 1. When env reaches ramp_len_p, go to PLAY.
  - PLAY: sel_ready_o = 1. Accepting code == cur is a no-op. Any other code (including mute) sets pend = code and goes to RAMP_DOWN.
  - RAMP_DOWN: sel_ready_o = 0. Each tick env -= 1. When env reaches 0:
    - if pend != 0: cur = pend, go to RAMP_UP (same cycle);
    - else: cur = 0, go to IDLE.
- A request arriving in the same cycle as a tick is accepted; that tick uses the old cur and env.
- Sticky flags clear only on reset.

Test Plan:
Bench parameters: clks_per_sample_p = 4, ramp_len_p = 4. Each generator presents a constant sample with gen_valid_i = 1111 unless stated. Sine presents 1048576 and square presents 2097152.
1. Assert reset_i mid-cycle -> all outputs 0 immediately and sel_ready_o = 1. After release: first gen_ready_o pulse absent (cur = 0), valid_o = 1 two cycles after the 4th edge, data_o = 0.
2. Select 0001 with gain 256 -> gen_ready_o = 0001 on ticks; successive data_o = 0, 262144, 524288, 786432, then 1048576 steady (PLAY). sel_ready_o = 0 during the ramp.
3. From PLAY select 0010 -> data_o = 1048576, 786432, 524288, 262144 (sine); then 0, 524288, ... (square); gen_ready_o switches from 0001 to 0010 with no overlap.
4. In PLAY with gen_data_i = -3 and gain_i = 128 -> data_o = -2 (floor). gain_i = 400 -> treated as 256, data_o = -3.
5. Hold ready_i = 0 across 2 ticks -> data_o = the newer sample and overrun_o = 1. Drop gen_valid_i[cur] at one tick -> that sample is 0 and underrun_o = 1.
6. Select 0011 from PLAY -> treated as mute: ramps down to IDLE, cur = 0000, data_o = 0. Reset during RAMP_UP -> immediate IDLE, env = 0, all outputs 0.

Source files
------------

// File: rtl/wave_voice_sequencer_if.sv
// Selection, generator and sink signals of the voice sequencer.
// master drives requests and samples; slave is the sequencer.
interface wave_voice_sequencer_if #(
  parameter int width_p = 24
);
  logic [3:0]               sel_i;
  logic                     sel_valid_i;
  logic                     sel_ready_o;
  logic [8:0]               gain_i;
  logic [3:0]               gen_ready_o;
  logic [3:0]               gen_valid_i;
  logic [4*width_p-1:0]     gen_data_i;
  logic signed [width_p-1:0] data_o;
  logic                     valid_o;
  logic                     ready_i;
  logic                     overrun_o;
  logic                     underrun_o;

  modport master (
    output sel_i, sel_valid_i, gain_i,
    output gen_valid_i, gen_data_i, ready_i,
    input  sel_ready_o, gen_ready_o,
    input  data_o, valid_o,
    input  overrun_o, underrun_o
  );

  modport slave (
    input  sel_i, sel_valid_i, gain_i,
    input  gen_valid_i, gen_data_i, ready_i,
    output sel_ready_o, gen_ready_o,
    output data_o, valid_o,
    output overrun_o, underrun_o
  );
endinterface

// File: rtl/wave_voice_sequencer.sv
// Sample-tick scheduler for four voices with click-free
// envelope ramps around every voice change, gain and stream out.
module wave_voice_sequencer #(
  parameter int width_p           = 24,
  parameter int clks_per_sample_p = 385,
  parameter int ramp_len_p        = 64
) (
  input logic clk_i,
  input logic reset_i,
  wave_voice_sequencer_if.slave bus
);
  localparam int cnt_w = $clog2(clks_per_sample_p);
  localparam int lg_w  = $clog2(ramp_len_p);
  localparam int env_w = lg_w + 1;
  localparam int p1_w  = width_p + env_w + 1;
  localparam int p2_w  = width_p + 10;
  localparam logic [cnt_w-1:0] cnt_last =
    cnt_w'(clks_per_sample_p - 1);
  localparam logic [env_w-1:0] env_full =
    env_w'(ramp_len_p);
  localparam logic [env_w-1:0] env_one = env_w'(1);

  typedef enum logic [1:0] {
    IDLE, RAMP_UP, PLAY, RAMP_DOWN
  } state_t;

  state_t state_q, state_d;
  logic [3:0] cur_q, cur_d;
  logic [3:0] pend_q, pend_d;
  logic [env_w-1:0] env_q, env_d;
  logic [cnt_w-1:0] cnt_q;
  logic tick, accept, hit;
  logic [3:0] code;
  logic signed [width_p-1:0] src, s1_q, s2_q;
  logic signed [p1_w-1:0] p1;
  logic signed [p2_w-1:0] p2;
  logic [8:0] gain_q;
  logic v1_q, v2_q;

  assign tick = (cnt_q == cnt_last);

  always_ff @(posedge clk_i or posedge reset_i)
    if (reset_i)   cnt_q <= '0;
    else if (tick) cnt_q <= '0;
    else           cnt_q <= cnt_q + 1'b1;

  // Anything that is not exactly one voice means mute.
  assign code = ($countones(bus.sel_i) == 1)
              ? bus.sel_i : 4'b0000;

  assign bus.sel_ready_o = (state_q == IDLE) ||
                           (state_q == PLAY);
  assign accept = bus.sel_valid_i & bus.sel_ready_o;
  assign bus.gen_ready_o = cur_q & {4{tick}};

  always_ff @(posedge clk_i or posedge reset_i)
    if (reset_i) begin
      state_q <= IDLE;
      cur_q   <= '0;
      pend_q  <= '0;
      env_q   <= '0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      pend_q  <= pend_d;
      env_q   <= env_d;
    end

  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    pend_d  = pend_q;
    env_d   = env_q;
    unique case (state_q)
      IDLE:
        if (accept && code != 4'b0000) begin
          cur_d   = code;
          env_d   = '0;
          state_d = RAMP_UP;
        end
      RAMP_UP:
        if (tick) begin
          env_d = env_q + 1'b1;
          if (env_q + 1'b1 == env_full)
            state_d = PLAY;
        end
      PLAY:
        if (accept && code != cur_q) begin
          pend_d  = code;
          state_d = RAMP_DOWN;
        end
      RAMP_DOWN:
        if (tick) begin
          env_d = env_q - 1'b1;
          if (env_q == env_one) begin
            if (pend_q != 4'b0000) begin
              cur_d   = pend_q;
              state_d = RAMP_UP;
            end else begin
              cur_d   = '0;
              state_d = IDLE;
            end
          end
        end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    src = '0;
    hit = 1'b0;
    unique case (1'b1)
      cur_q[0]: begin
        hit = bus.gen_valid_i[0];
        src = bus.gen_data_i[0*width_p +: width_p];
      end
      cur_q[1]: begin
        hit = bus.gen_valid_i[1];
        src = bus.gen_data_i[1*width_p +: width_p];
      end
      cur_q[2]: begin
        hit = bus.gen_valid_i[2];
        src = bus.gen_data_i[2*width_p +: width_p];
      end
      cur_q[3]: begin
        hit = bus.gen_valid_i[3];
        src = bus.gen_data_i[3*width_p +: width_p];
      end
      default: ;
    endcase
    if (!hit) src = '0;
  end

  assign p1 = $signed(p1_w'(src)) *
              $signed(p1_w'({1'b0, env_q}));
  assign p2 = $signed(p2_w'(s1_q)) *
              $signed(p2_w'({1'b0, gain_q}));

  always_ff @(posedge clk_i or posedge reset_i)
    if (reset_i) begin
      s1_q   <= '0;
      gain_q <= '0;
      v1_q   <= 1'b0;
      s2_q   <= '0;
      v2_q   <= 1'b0;
    end else begin
      v1_q <= tick;
      v2_q <= v1_q;
      if (tick) begin
        s1_q   <= width_p'(p1 >>> lg_w);
        gain_q <= (bus.gain_i > 9'd256) ? 9'd256
                                        : bus.gain_i;
      end
      if (v1_q) s2_q <= width_p'(p2 >>> 8);
    end

  always_ff @(posedge clk_i or posedge reset_i)
    if (reset_i) begin
      bus.data_o     <= '0;
      bus.valid_o    <= 1'b0;
      bus.overrun_o  <= 1'b0;
      bus.underrun_o <= 1'b0;
    end else begin
      if (v2_q) begin
        bus.data_o  <= s2_q;
        bus.valid_o <= 1'b1;
        if (bus.valid_o && !bus.ready_i)
          bus.overrun_o <= 1'b1;
      end else if (bus.ready_i) begin
        bus.valid_o <= 1'b0;
      end
      if (tick && cur_q != 4'b0000 && !hit)
        bus.underrun_o <= 1'b1;
    end
endmodule

// File: tb/tb_wave_voice_sequencer.sv
// Scoreboard bench: expected samples queued per tick and
// compared when each result reaches the sink.
`timescale 1ns/1ps
module tb_wave_voice_sequencer;
  localparam int W = 24;
  localparam int C = 4;
  localparam int R = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  wave_voice_sequencer_if #(.width_p(W)) bus();

  wave_voice_sequencer #(
    .width_p(W),
    .clks_per_sample_p(C),
    .ramp_len_p(R)
  ) dut (
    .clk_i(clk),
    .reset_i(rst),
    .bus(bus)
  );

  logic signed [W-1:0] gd [4];
  assign bus.gen_data_i = {gd[3], gd[2], gd[1], gd[0]};

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int exp_v;
  int q[$];

  always @(posedge clk or posedge rst)
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;

  // Results of the tick on edge 4k are visible after edge 4k+2.
  always @(negedge clk) begin
    if (!rst && cyc % C == 2 && q.size() > 0) begin
      exp_v = q.pop_front();
      tests++;
      if (bus.valid_o !== 1'b1 || bus.data_o !== W'(exp_v)) begin
        fails++;
        $display("FAIL sample: data_o=%0d valid_o=%0b, expected %0d valid 1",
                 bus.data_o, bus.valid_o, exp_v);
      end
    end
  end

  task automatic align();
    do @(negedge clk); while (cyc % C != 2);
    #1;
  endtask

  task automatic wait_empty();
    int n = 0;
    while (q.size() != 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    #1;
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL timeout: %0d samples pending, expected 0", q.size());
      q.delete();
    end
  endtask

  task automatic request(input logic [3:0] code);
    bus.sel_i = code;
    bus.sel_valid_i = 1'b1;
    @(posedge clk);
    #1 bus.sel_valid_i = 1'b0;
  endtask

  task automatic check_idle_outputs(input string tag);
    tests++;
    if (bus.valid_o !== 1'b0 || bus.data_o !== '0 ||
        bus.gen_ready_o !== 4'b0 || bus.overrun_o !== 1'b0 ||
        bus.underrun_o !== 1'b0) begin
      fails++;
      $display("FAIL %s outputs: v=%0b d=%0d gr=%b ov=%0b un=%0b, expected all 0",
               tag, bus.valid_o, bus.data_o, bus.gen_ready_o,
               bus.overrun_o, bus.underrun_o);
    end
    tests++;
    if (bus.sel_ready_o !== 1'b1) begin
      fails++;
      $display("FAIL %s sel_ready: got %0b, expected 1", tag, bus.sel_ready_o);
    end
  endtask

  task automatic test_reset();
    bus.sel_i = 4'b0;
    bus.sel_valid_i = 1'b0;
    bus.gain_i = 9'd256;
    bus.gen_valid_i = 4'hF;
    bus.ready_i = 1'b1;
    gd[0] = 24'sd1048576;
    gd[1] = 24'sd2097152;
    gd[2] = 24'sd3;
    gd[3] = 24'sd4;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1 check_idle_outputs("reset");
    @(negedge clk) rst = 1'b0;
    do @(negedge clk); while (cyc != 3);
    tests++;
    if (bus.gen_ready_o !== 4'b0) begin
      fails++;
      $display("FAIL first_tick gen_ready: got %b, expected 0000", bus.gen_ready_o);
    end
    do @(negedge clk); while (cyc != 5);
    tests++;
    if (bus.valid_o !== 1'b0) begin
      fails++;
      $display("FAIL early_valid: got %0b, expected 0", bus.valid_o);
    end
    @(negedge clk);
    tests++;
    if (bus.valid_o !== 1'b1 || bus.data_o !== '0) begin
      fails++;
      $display("FAIL idle_sample: v=%0b d=%0d, expected v=1 d=0",
               bus.valid_o, bus.data_o);
    end
  endtask

  task automatic test_ramp_up();
    logic [3:0] gr;
    align();
    q.push_back(0);
    q.push_back(262144);
    q.push_back(524288);
    q.push_back(786432);
    q.push_back(1048576);
    q.push_back(1048576);
    request(4'b0001);
    for (int i = 0; i < 6; i++) begin
      do @(negedge clk); while (cyc % C != 3);
      gr = bus.gen_ready_o;
      tests++;
      if (gr !== 4'b0001) begin
        fails++;
        $display("FAIL ramp_up gen_ready[%0d]: got %b, expected 0001", i, gr);
      end
      tests++;
      if (bus.sel_ready_o !== (i >= 4)) begin
        fails++;
        $display("FAIL ramp_up sel_ready[%0d]: got %0b, expected %0b",
                 i, bus.sel_ready_o, (i >= 4));
      end
    end
    wait_empty();
  endtask

  task automatic test_switch();
    logic [3:0] want;
    align();
    q.push_back(1048576);
    q.push_back(786432);
    q.push_back(524288);
    q.push_back(262144);
    q.push_back(0);
    q.push_back(524288);
    q.push_back(1048576);
    q.push_back(1572864);
    q.push_back(2097152);
    request(4'b0010);
    for (int i = 0; i < 9; i++) begin
      do @(negedge clk); while (cyc % C != 3);
      want = (i < 4) ? 4'b0001 : 4'b0010;
      tests++;
      if (bus.gen_ready_o !== want) begin
        fails++;
        $display("FAIL switch gen_ready[%0d]: got %b, expected %b",
                 i, bus.gen_ready_o, want);
      end
    end
    wait_empty();
  endtask

  task automatic test_gain_floor();
    align();
    gd[1] = -24'sd3;
    bus.gain_i = 9'd128;
    q.push_back(-2);
    wait_empty();
    align();
    bus.gain_i = 9'd400;
    q.push_back(-3);
    wait_empty();
  endtask

  task automatic test_overrun();
    align();
    bus.gain_i = 9'd256;
    tests++;
    if (bus.overrun_o !== 1'b0) begin
      fails++;
      $display("FAIL overrun_pre: got %0b, expected 0", bus.overrun_o);
    end
    bus.ready_i = 1'b0;
    gd[1] = 24'sd100;
    repeat (2) @(negedge clk);
    gd[1] = 24'sd200;
    repeat (6) @(negedge clk);
    tests++;
    if (bus.data_o !== 24'sd200 || bus.valid_o !== 1'b1) begin
      fails++;
      $display("FAIL overrun_data: d=%0d v=%0b, expected d=200 v=1",
               bus.data_o, bus.valid_o);
    end
    tests++;
    if (bus.overrun_o !== 1'b1) begin
      fails++;
      $display("FAIL overrun_flag: got %0b, expected 1", bus.overrun_o);
    end
    bus.ready_i = 1'b1;
    @(negedge clk);
    tests++;
    if (bus.valid_o !== 1'b0) begin
      fails++;
      $display("FAIL drain_valid: got %0b, expected 0", bus.valid_o);
    end
  endtask

  task automatic test_underrun();
    align();
    tests++;
    if (bus.underrun_o !== 1'b0) begin
      fails++;
      $display("FAIL underrun_pre: got %0b, expected 0", bus.underrun_o);
    end
    bus.gen_valid_i = 4'b1101;
    q.push_back(0);
    q.push_back(200);
    repeat (2) @(negedge clk);
    bus.gen_valid_i = 4'hF;
    wait_empty();
    tests++;
    if (bus.underrun_o !== 1'b1) begin
      fails++;
      $display("FAIL underrun_flag: got %0b, expected 1", bus.underrun_o);
    end
  endtask

  task automatic test_mute_code();
    logic [3:0] want;
    align();
    q.push_back(200);
    q.push_back(150);
    q.push_back(100);
    q.push_back(50);
    q.push_back(0);
    q.push_back(0);
    request(4'b0011);
    for (int i = 0; i < 6; i++) begin
      do @(negedge clk); while (cyc % C != 3);
      want = (i < 4) ? 4'b0010 : 4'b0000;
      tests++;
      if (bus.gen_ready_o !== want) begin
        fails++;
        $display("FAIL mute gen_ready[%0d]: got %b, expected %b",
                 i, bus.gen_ready_o, want);
      end
    end
    wait_empty();
    tests++;
    if (bus.sel_ready_o !== 1'b1) begin
      fails++;
      $display("FAIL mute_idle sel_ready: got %0b, expected 1", bus.sel_ready_o);
    end
  endtask

  task automatic test_reset_in_ramp();
    gd[0] = 24'sd1048576;
    align();
    request(4'b0001);
    repeat (6) @(negedge clk);
    @(posedge clk);
    #3 rst = 1'b1;
    #1 check_idle_outputs("ramp_reset");
    q.delete();
    @(negedge clk) rst = 1'b0;
    do @(negedge clk); while (cyc != 3);
    tests++;
    if (bus.gen_ready_o !== 4'b0) begin
      fails++;
      $display("FAIL post_reset gen_ready: got %b, expected 0000", bus.gen_ready_o);
    end
    align();
    q.push_back(0);
    q.push_back(262144);
    q.push_back(524288);
    q.push_back(786432);
    q.push_back(1048576);
    request(4'b0001);
    wait_empty();
  endtask

  initial begin
    test_reset();
    test_ramp_up();
    test_switch();
    test_gain_floor();
    test_overrun();
    test_underrun();
    test_mute_code();
    test_reset_in_ramp();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
